// File: rtl/audio_sample_fifo.sv
// Sample-rate FIFO between the microphone capture stage and the PWM stage.
// Samples are buffered, then popped at one sample per RATE_DIV clocks once half full.
module audio_sample_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int RATE_DIV = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          din,
    input  logic                       din_valid,
    input  logic                       clear_flags,
    output logic [DATA_W-1:0]          dout,
    output logic                       dout_strobe,
    output logic [$clog2(DEPTH):0]     fill,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;
    localparam int CNT_W  = (RATE_DIV > 2) ? $clog2(RATE_DIV) : 1;
    localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic {PREFILL, RUN} state_t;

    state_t              state_reg, state_next;
    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [FILL_W-1:0]   fill_reg, fill_next;
    logic [CNT_W-1:0]    count_reg, count_next;
    logic [DATA_W-1:0]   dout_reg;
    logic                strobe_reg;
    logic                overflow_reg, overflow_next;
    logic                underflow_reg, underflow_next;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic tick, full, empty, wr_en, pop_en, overflow_set, underflow_set;

    always_comb begin
        tick          = (count_reg == CNT_W'(RATE_DIV - 1));
        full          = (fill_reg == FILL_W'(DEPTH));
        empty         = (fill_reg == '0);
        // Full/empty are judged on the pre-edge fill, so a pop never frees room for a same-cycle write.
        wr_en         = din_valid && !full;
        pop_en        = (state_reg == RUN) && tick && !empty;
        overflow_set  = din_valid && full;
        underflow_set = (state_reg == RUN) && tick && empty;
    end

    always_comb begin
        state_next     = state_reg;
        fill_next      = fill_reg;
        count_next     = tick ? '0 : count_reg + 1'b1;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;

        case (state_reg)
            PREFILL: if (fill_reg >= FILL_W'(DEPTH / 2)) state_next = RUN;
            RUN:     if (underflow_set) state_next = PREFILL;
            default: state_next = PREFILL;
        endcase

        case ({wr_en, pop_en})
            2'b10:   fill_next = fill_reg + 1'b1;
            2'b01:   fill_next = fill_reg - 1'b1;
            default: fill_next = fill_reg;
        endcase

        if (clear_flags) begin
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end
        if (overflow_set)  overflow_next  = 1'b1;
        if (underflow_set) underflow_next = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= PREFILL;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            fill_reg      <= '0;
            count_reg     <= '0;
            dout_reg      <= MIDSCALE;
            strobe_reg    <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            fill_reg      <= fill_next;
            count_reg     <= count_next;
            strobe_reg    <= tick;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
            if (wr_en)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                dout_reg   <= mem[rd_ptr_reg];
            end
        end
    end

    // Storage carries no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_reg] <= din;
    end

    assign dout        = dout_reg;
    assign dout_strobe = strobe_reg;
    assign fill        = fill_reg;
    assign overflow    = overflow_reg;
    assign underflow   = underflow_reg;

endmodule
